// File: rtl/cskip_pkg.sv
// Shared definitions for the pipelined carry-skip adder/subtractor:
// operation mode encoding and the elaboration-time parameter check.
package cskip_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } mode_e;

    // True when the width splits evenly into STAGES slices of whole
    // BLOCK-bit skip blocks, with at least one block per stage.
    function automatic bit legal_cfg(input int width, input int block, input int stages);
        if (width < 1 || block < 1 || stages < 1) return 1'b0;
        if ((width % (block * stages)) != 0) return 1'b0;
        return (stages <= (width / block));
    endfunction

endpackage

// File: rtl/cskip_block.sv
// One carry-skip block: BLOCK-bit ripple adder whose carry out bypasses the
// ripple chain when every bit of the block propagates.
module cskip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co
);

    logic [BLOCK-1:0] w_p;
    logic [BLOCK:0]   w_c;

    assign w_p = a ^ b;

    // Ripple the carry bit by bit through the block.
    // NOTE: w_c[0] is set first and the loop writes every remaining bit on
    // each evaluation, so no latch can be inferred.
    always_comb begin
        w_c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            w_c[i+1] = (a[i] & b[i]) | (w_p[i] & w_c[i]);
        end
    end

    assign s  = w_p ^ w_c[BLOCK-1:0];
    // When the whole block propagates, the incoming carry skips straight out.
    assign co = (&w_p) ? ci : w_c[BLOCK];

endmodule

// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready handshake.
// Stage k adds bit slice k; higher operand slices ride forward in the
// stage registers while finished low result slices accumulate beside them,
// so the final stage register holds the realigned full-width sum.
module cskip_adder_pipe
    import cskip_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int NBLK  = SLICE / BLOCK;

    if (!legal_cfg(WIDTH, BLOCK, STAGES)) begin : g_bad_cfg
        $error("cskip_adder_pipe: illegal WIDTH/BLOCK/STAGES combination");
    end

    logic             w_advance;
    logic             w_sub;
    logic             w_cin_eff;
    logic [WIDTH-1:0] w_b_eff;

    // The whole pipeline moves as one unless a finished result is waiting.
    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    // Subtraction is a + ~b + 1; the external carry-in only matters for add.
    assign w_sub     = (mode_e'(sub) == SUB);
    assign w_b_eff   = w_sub ? ~b : b;
    assign w_cin_eff = w_sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE-1:0]         w_as;
        logic [SLICE-1:0]         w_bs;
        logic [SLICE-1:0]         w_ss;
        logic                     w_ci;
        logic                     w_vi;
        logic                     w_co;
        logic [(k+1)*SLICE-1:0]   w_so;
        logic [(k+1)*SLICE-1:0]   r_s;
        logic                     r_c;
        logic                     r_v;

        if (k == 0) begin : g_src
            assign w_as = a[SLICE-1:0];
            assign w_bs = w_b_eff[SLICE-1:0];
            assign w_ci = w_cin_eff;
            assign w_vi = in_valid;
            assign w_so = w_ss;
        end else begin : g_src
            assign w_as = g_stage[k-1].g_hi.r_ahi[SLICE-1:0];
            assign w_bs = g_stage[k-1].g_hi.r_bhi[SLICE-1:0];
            assign w_ci = g_stage[k-1].r_c;
            assign w_vi = g_stage[k-1].r_v;
            assign w_so = {w_ss, g_stage[k-1].r_s};
        end

        for (genvar j = 0; j < NBLK; j++) begin : g_blk
            logic w_bci;
            logic w_bco;

            if (j == 0) begin : g_ci
                assign w_bci = w_ci;
            end else begin : g_ci
                assign w_bci = g_blk[j-1].w_bco;
            end

            cskip_block #(
                .BLOCK (BLOCK)
            ) u_block (
                .a  (w_as[j*BLOCK +: BLOCK]),
                .b  (w_bs[j*BLOCK +: BLOCK]),
                .ci (w_bci),
                .s  (w_ss[j*BLOCK +: BLOCK]),
                .co (w_bco)
            );
        end

        assign w_co = g_blk[NBLK-1].w_bco;

        // Stage register: valid bit always follows its slot; data only
        // loads with a real operand so outputs hold across bubbles.
        // NOTE: non-blocking assignments let every stage sample its
        // predecessor's pre-edge value regardless of evaluation order.
        // NOTE: data registers are reset as well so sum/cout/ovf read 0
        // after reset, not only the valid bit.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_advance) begin
                r_v <= w_vi;
                if (w_vi) begin
                    r_s <= w_so;
                    r_c <= w_co;
                end
            end
        end

        if (k < STAGES - 1) begin : g_hi
            localparam int HI = WIDTH - (k + 1) * SLICE;
            logic [HI-1:0] w_ahi;
            logic [HI-1:0] w_bhi;
            logic [HI-1:0] r_ahi;
            logic [HI-1:0] r_bhi;

            if (k == 0) begin : g_hsrc
                assign w_ahi = a[WIDTH-1:SLICE];
                assign w_bhi = w_b_eff[WIDTH-1:SLICE];
            end else begin : g_hsrc
                assign w_ahi = g_stage[k-1].g_hi.r_ahi[HI+SLICE-1:SLICE];
                assign w_bhi = g_stage[k-1].g_hi.r_bhi[HI+SLICE-1:SLICE];
            end

            // Carry the not-yet-added operand slices forward with the slot.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_ahi <= '0;
                    r_bhi <= '0;
                end else if (w_advance && w_vi) begin
                    r_ahi <= w_ahi;
                    r_bhi <= w_bhi;
                end
            end
        end

        if (k == STAGES - 1) begin : g_ovf
            logic w_cmsb;
            logic r_ovf;

            // Carry into the MSB recovered from the MSB sum bit and operands.
            assign w_cmsb = w_ss[SLICE-1] ^ w_as[SLICE-1] ^ w_bs[SLICE-1];

            // Signed overflow flag, registered alongside the final slice.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_ovf <= 1'b0;
                end else if (w_advance && w_vi) begin
                    r_ovf <= w_cmsb ^ w_co;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign sum       = g_stage[STAGES-1].r_s;
    assign cout      = g_stage[STAGES-1].r_c;
    assign ovf       = g_stage[STAGES-1].g_ovf.r_ovf;

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Scoreboard bench: four configurations share one randomized operand stream.
// Config 0 (BLOCK=4, STAGES=2) sees bench-driven backpressure; the others
// always accept results. Each config pushes the model result on input
// transfer and its monitor compares whenever a result is presented.
module tb_cskip_adder_pipe;

    localparam int W    = 32;
    localparam int NCFG = 4;

    function automatic int cfg_block(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_stages(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 4;
        endcase
    endfunction

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        int           stl;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         sub;
    logic         cin;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         in_ready_v  [NCFG];
    logic         out_valid_v [NCFG];
    logic         out_ready_v [NCFG];
    logic         cout_v      [NCFG];
    logic         ovf_v       [NCFG];
    logic [W-1:0] sum_v       [NCFG];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rnd_done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic isub, input logic icin);
        exp_t           e;
        longint         sa;
        longint         sb;
        longint         sr;
        longint         ua;
        longint         ub;
        ua = longint'(64'(ia));
        ub = longint'(64'(ib));
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        if (isub) begin
            sr     = sa - sb;
            e.sum  = ia - ib;
            e.cout = (ua >= ub);
        end else begin
            sr     = sa + sb + longint'(64'(icin));
            e.sum  = ia + ib + 32'(icin);
            e.cout = ((ua + ub + longint'(64'(icin))) >= 64'sd4294967296);
        end
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.acc = 0;
        e.stl = 0;
        return e;
    endfunction

    for (genvar i = 0; i < NCFG; i++) begin : g_cfg
        localparam int BL = cfg_block(i);
        localparam int ST = cfg_stages(i);

        exp_t q[$];
        int   stalls = 0;

        assign out_ready_v[i] = (i == 0) ? out_ready : 1'b1;

        cskip_adder_pipe #(
            .WIDTH  (W),
            .BLOCK  (BL),
            .STAGES (ST)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[i]),
            .a         (a),
            .b         (b),
            .sub       (sub),
            .cin       (cin),
            .out_valid (out_valid_v[i]),
            .out_ready (out_ready_v[i]),
            .sum       (sum_v[i]),
            .cout      (cout_v[i]),
            .ovf       (ovf_v[i])
        );

        // Monitor and scoreboard, sampled mid-cycle away from the clock edge.
        always @(negedge clk) begin
            exp_t e;
            if (!rst) begin
                q.delete();
                stalls = 0;
            end else begin
                if (out_valid_v[i]) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL cfg%0d unexpected result: got sum 0x%0h, expected no output", i, sum_v[i]);
                    end else begin
                        check($sformatf("cfg%0d sum", i),  sum_v[i],        q[0].sum);
                        check($sformatf("cfg%0d cout", i), 32'(cout_v[i]),  32'(q[0].cout));
                        check($sformatf("cfg%0d ovf", i),  32'(ovf_v[i]),   32'(q[0].ovf));
                        if (out_ready_v[i]) begin
                            check($sformatf("cfg%0d latency", i), 32'(cyc - q[0].acc),
                                  32'(ST + stalls - q[0].stl));
                            void'(q.pop_front());
                        end
                    end
                end
                check($sformatf("cfg%0d in_ready", i), 32'(in_ready_v[i]),
                      32'(!(out_valid_v[i] && !out_ready_v[i])));
                if (out_valid_v[i] && !out_ready_v[i]) stalls++;
                if (in_valid && in_ready_v[i]) begin
                    e     = model(a, b, sub, cin);
                    e.acc = cyc;
                    e.stl = stalls;
                    q.push_back(e);
                end
            end
        end
    end

    function automatic int pending();
        return g_cfg[0].q.size() + g_cfg[1].q.size() + g_cfg[2].q.size() + g_cfg[3].q.size();
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Present one operation and hold it until config 0 accepts it.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic icin);
        int n = 0;
        a        = ia;
        b        = ib;
        sub      = isub;
        cin      = icin;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready_v[0] && n < 200);
        if (!in_ready_v[0]) begin
            checks++;
            errors++;
            $display("FAIL issue timeout: got in_ready 0 for %0d cycles, expected acceptance", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (pending() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain pending", 32'(pending()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cin       = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("cfg%0d reset out_valid", i), 32'(out_valid_v[i]), 32'd0);
            check($sformatf("cfg%0d reset sum", i),       sum_v[i],            32'd0);
            check($sformatf("cfg%0d reset cout", i),      32'(cout_v[i]),      32'd0);
            check($sformatf("cfg%0d reset ovf", i),       32'(ovf_v[i]),       32'd0);
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("cfg%0d in_ready after reset", i), 32'(in_ready_v[i]), 32'd1);
        end
        @(posedge clk);
        #1;

        // Simple add, full skip chain, overflow, subtract with borrow.
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        idle(4);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        idle(6);

        // Backpressure: four back-to-back ops, consumer stalls cycles 2..5.
        fork
            begin
                issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
                issue(32'hF000_0000, 32'h1000_0000, 1'b0, 1'b1);
                issue(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
                issue(32'h89AB_CDEF, 32'h7654_3210, 1'b0, 1'b1);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        idle(2);

        // Reset with two operations in flight.
        issue(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
        issue(32'h0000_0300, 32'h0000_0400, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("cfg%0d out_valid at reset", i), 32'(out_valid_v[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("cfg0 out_valid after flush", 32'(out_valid_v[0]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Randomized regression with random gaps and random backpressure.
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(4) == 0) begin
                        idle(1);
                    end else begin
                        issue(rand_op(), rand_op(), 1'($urandom_range(1)), 1'($urandom_range(1)));
                    end
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3) != 0);
                end
            end
        join
        drain();
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
